// File: rtl/dac_frame_rx.sv
// Receive side of the 24-bit DAC serial link: shifts in header+sample while sync is low,
// commits the frame into a channel bank. Optional header check: DAC_RX_HDR_CHECK_EN.
module dac_frame_rx #(
    parameter int                   HDR_BITS  = 8,
    parameter int                   DATA_BITS = 16,
    parameter int                   N_CH      = 4,
    parameter logic [DATA_BITS-1:0] CH_INIT   = 16'h8000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sync,
    input  logic                          din,
    output logic                          frame_valid,
    output logic [HDR_BITS-1:0]           frame_hdr,
    output logic [$clog2(N_CH)-1:0]       frame_addr,
    output logic [DATA_BITS-1:0]          frame_data,
    output logic [N_CH*DATA_BITS-1:0]     ch_val,
    output logic [15:0]                   frame_cnt,
    output logic                          short_err,
    output logic                          overrun_err,
    output logic                          hdr_err
);

    localparam int FRAME_BITS = HDR_BITS + DATA_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam int AW         = $clog2(N_CH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    typedef struct packed {
        logic [HDR_BITS-1:0]  hdr;
        logic [DATA_BITS-1:0] data;
    } frame_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [FRAME_BITS-1:0]   sreg;
    frame_t                  rx;
    logic                    shift_en, last_bit, short_set, ovr_set;
    logic                    ovr_seen, commit_pend, hdr_bad, commit_ok;
    logic [N_CH-1:0][DATA_BITS-1:0] bank;

    assign rx     = frame_t'(sreg);
    assign ch_val = bank;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        last_bit  = 1'b0;
        short_set = 1'b0;
        ovr_set   = 1'b0;
        case (state)
            IDLE: begin
                if (!sync) begin
                    shift_en  = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (sync) begin
                    short_set = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    shift_en = 1'b1;
                    if (cnt == CNT_W'(FRAME_BITS - 1)) begin
                        last_bit  = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                // only the first excess bit is flagged; the rest are dropped silently
                if (sync)           state_nxt = IDLE;
                else if (!ovr_seen) ovr_set   = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef DAC_RX_HDR_CHECK_EN
    localparam logic [4:0] HDR_CMD = 5'b00010;
    assign hdr_bad = (rx.hdr[HDR_BITS-1 -: 5] != HDR_CMD);

    always_ff @(posedge clk) begin
        if (rst) hdr_err <= 1'b0;
        else     hdr_err <= commit_pend & hdr_bad;
    end
`else
    assign hdr_bad = 1'b0;
    assign hdr_err = 1'b0;
`endif

    assign commit_ok = commit_pend & ~hdr_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            sreg        <= '0;
            ovr_seen    <= 1'b0;
            commit_pend <= 1'b0;
            short_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            short_err   <= short_set;
            overrun_err <= ovr_set;
            commit_pend <= last_bit;
            if (shift_en) begin
                sreg <= {sreg[FRAME_BITS-2:0], din};
                cnt  <= (state == IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
            end else if (state_nxt == IDLE) begin
                cnt <= '0;
            end
            if (last_bit)     ovr_seen <= 1'b0;
            else if (ovr_set) ovr_seen <= 1'b1;
        end
    end

    // commit lands one edge after the 24th bit, from the now-stable shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_valid <= 1'b0;
            frame_hdr   <= '0;
            frame_addr  <= '0;
            frame_data  <= '0;
            frame_cnt   <= '0;
            for (int n = 0; n < N_CH; n++) bank[n] <= CH_INIT;
        end else begin
            frame_valid <= commit_ok;
            if (commit_ok) begin
                frame_hdr  <= rx.hdr;
                frame_addr <= rx.hdr[AW:1];
                frame_data <= rx.data;
                frame_cnt  <= frame_cnt + 16'd1;
                for (int n = 0; n < N_CH; n++)
                    if (rx.hdr[AW:1] == AW'(n)) bank[n] <= rx.data;
            end
        end
    end

endmodule

// File: tb/tb_dac_frame_rx.sv
// Frame-level scoreboard bench for dac_frame_rx: predicts pulses and bank contents from
// the frames sent, compares every cycle, plus literal spot checks.
module tb_dac_frame_rx;

    logic        clk = 1'b0, rst = 1'b1, sync = 1'b1, din = 1'b0;
    logic        frame_valid, short_err, overrun_err, hdr_err;
    logic [7:0]  frame_hdr;
    logic [1:0]  frame_addr;
    logic [15:0] frame_data, frame_cnt;
    logic [63:0] ch_val;

    dac_frame_rx dut (
        .clk(clk), .rst(rst), .sync(sync), .din(din),
        .frame_valid(frame_valid), .frame_hdr(frame_hdr), .frame_addr(frame_addr),
        .frame_data(frame_data), .ch_val(ch_val), .frame_cnt(frame_cnt),
        .short_err(short_err), .overrun_err(overrun_err), .hdr_err(hdr_err)
    );

    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    localparam int EV_COMMIT = 0, EV_SHORT = 1, EV_OVR = 2, EV_RST = 3;
    typedef struct {
        int          cyc;
        int          kind;
        logic [23:0] frm;
    } ev_t;
    ev_t evq[$];

    logic [3:0][15:0] m_ch;
    logic [7:0]       m_hdr;
    logic [15:0]      m_data, m_cnt;
    int  total = 0, bad = 0, fv_seen = 0;
    bit  check_on = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s at edge %0d: got %h want %h", nm, edges, act, exp);
        end
    endtask

    function automatic bit hdr_accepted(input logic [7:0] h);
`ifdef DAC_RX_HDR_CHECK_EN
        return h[7:3] == 5'b00010;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        m_ch   = {4{16'h8000}};
        m_hdr  = '0;
        m_data = '0;
        m_cnt  = '0;
    endtask

    // Per-cycle compare: apply every event due at this edge, then check all outputs.
    always @(negedge clk) begin
        bit  e_fv, e_se, e_oe, e_he;
        ev_t e;
        e_fv = 0; e_se = 0; e_oe = 0; e_he = 0;
        if (frame_valid === 1'b1) fv_seen++;
        if (check_on) begin
            while (evq.size() > 0 && evq[0].cyc <= edges) begin
                e = evq.pop_front();
                if (e.cyc != edges) chk("event_time", 64'(edges), 64'(e.cyc));
                case (e.kind)
                    EV_COMMIT: begin
                        if (hdr_accepted(e.frm[23:16])) begin
                            e_fv   = 1;
                            m_hdr  = e.frm[23:16];
                            m_data = e.frm[15:0];
                            m_cnt  = m_cnt + 16'd1;
                            m_ch[e.frm[18:17]] = e.frm[15:0];
                        end else begin
                            e_he = 1;
                        end
                    end
                    EV_SHORT: e_se = 1;
                    EV_OVR:   e_oe = 1;
                    default:  model_reset();
                endcase
            end
            chk("frame_valid", 64'(frame_valid), 64'(e_fv));
            chk("short_err",   64'(short_err),   64'(e_se));
            chk("overrun_err", 64'(overrun_err), 64'(e_oe));
            chk("hdr_err",     64'(hdr_err),     64'(e_he));
            chk("frame_hdr",   64'(frame_hdr),   64'(m_hdr));
            chk("frame_addr",  64'(frame_addr),  64'(m_hdr[2:1]));
            chk("frame_data",  64'(frame_data),  64'(m_data));
            chk("frame_cnt",   64'(frame_cnt),   64'(m_cnt));
            chk("ch_val",      ch_val,           m_ch);
        end
    end

    // Drive one cycle's inputs just after the rising edge; they are sampled at edge edges+1.
    task automatic tick(input logic r, input logic s, input logic d);
        @(posedge clk);
        #1;
        rst  = r;
        sync = s;
        din  = d;
    endtask

    // sync low for nlow cycles carrying frm MSB first (junk beyond 24 bits), then gap high cycles.
    task automatic send(input logic [23:0] frm, input int nlow, input int gap);
        int e0;
        ev_t e;
        for (int i = 0; i < nlow; i++) begin
            tick(1'b0, 1'b0, (i < 24) ? frm[23-i] : 1'($urandom_range(0, 1)));
            if (i == 0) begin
                e0 = edges + 1;
                e.frm = frm;
                if (nlow < 24) begin
                    e.cyc = e0 + nlow; e.kind = EV_SHORT; evq.push_back(e);
                end else begin
                    e.cyc = e0 + 24; e.kind = EV_COMMIT; evq.push_back(e);
                    if (nlow > 24) begin
                        e.kind = EV_OVR; evq.push_back(e);
                    end
                end
            end
        end
        for (int i = 0; i < gap; i++) tick(1'b0, 1'b1, 1'b0);
    endtask

    task automatic settle();
        repeat (3) tick(1'b0, 1'b1, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        ev_t e;
        logic [23:0] part;
        model_reset();
        repeat (3) tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        check_on = 1'b1;
        @(negedge clk);
        chk("rst_cnt",   64'(frame_cnt), 64'h0);
        chk("rst_bank",  ch_val, {4{16'h8000}});
        chk("rst_pulse", 64'({frame_valid, short_err, overrun_err, hdr_err}), 64'h0);

        // single frame to ch0
        send({8'h10, 16'h8C8B}, 24, 1);
        settle();
        chk("t1_ch0",  64'(ch_val[15:0]), 64'h8C8B);
        chk("t1_addr", 64'(frame_addr),   64'h0);
        chk("t1_cnt",  64'(frame_cnt),    64'h1);

        // back-to-back frames with 1-cycle gaps
        send({8'h12, 16'h98F8}, 24, 1);
        send({8'h14, 16'h0000}, 24, 1);
        send({8'h16, 16'hFFFF}, 24, 1);
        settle();
        chk("t2_bank",   ch_val, {16'hFFFF, 16'h0000, 16'h98F8, 16'h8C8B});
        chk("t2_pulses", 64'(fv_seen), 64'd4);
        chk("t2_cnt",    64'(frame_cnt), 64'h4);

        // short frame
        send({8'h10, 16'h5555}, 10, 2);
        settle();
        chk("t3_cnt",  64'(frame_cnt), 64'h4);
        chk("t3_bank", ch_val, {16'hFFFF, 16'h0000, 16'h98F8, 16'h8C8B});

        // overrun: 30 bits low
        send({8'h10, 16'h1234}, 30, 1);
        settle();
        chk("t4_ch0", 64'(ch_val[15:0]), 64'h1234);
        chk("t4_cnt", 64'(frame_cnt),    64'h5);

        // header 8'h30
        send({8'h30, 16'hABCD}, 24, 1);
        settle();
`ifdef DAC_RX_HDR_CHECK_EN
        chk("t5_ch0", 64'(ch_val[15:0]), 64'h1234);
        chk("t5_cnt", 64'(frame_cnt),    64'h5);
`else
        chk("t5_ch0", 64'(ch_val[15:0]), 64'hABCD);
        chk("t5_cnt", 64'(frame_cnt),    64'h6);
`endif

        // reset after 12 bits, then a fresh frame to ch3
        part = 24'h12_3456;
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, part[23-i]);
        tick(1'b1, 1'b1, 1'b0);
        e.cyc = edges + 1; e.kind = EV_RST; e.frm = '0;
        evq.push_back(e);
        tick(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("t6_rst_cnt",  64'(frame_cnt), 64'h0);
        chk("t6_rst_bank", ch_val, {4{16'h8000}});
        chk("t6_rst_hdr",  64'(frame_hdr), 64'h0);
        send({8'h16, 16'h4F04}, 24, 1);
        settle();
        chk("t6_bank", ch_val, {16'h4F04, 16'h8000, 16'h8000, 16'h8000});
        chk("t6_cnt",  64'(frame_cnt), 64'h1);
        chk("t6_hdr",  64'(frame_hdr), 64'h16);

        chk("queue_drained", 64'(evq.size()), 64'h0);
        check_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
